// File: rtl/mips_display_pkg.sv
// Shared types and constants for the MIPS test-value seven-segment display.
package mips_display_pkg;

    // Digit scan state; DIG0 is the rightmost digit.
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_t;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned AN_W     = 4;
    localparam int unsigned VALUE_W  = 16;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [AN_W-1:0]  AN_OFF    = 4'b1111;

    // Active-low segment patterns, seg[6]=a .. seg[0]=g, indexed by nibble value.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
    import mips_display_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg_c
);

    // Table lookup of the segment pattern.
    always_comb begin
        seg_c = HEX_SEG[nibble];
    end

endmodule

// File: rtl/test_value_display.sv
// Four-digit multiplexed common-anode display of the 16-bit MIPS test value.
// The shadow copy of test_value only updates at frame boundaries so digits never tear.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank most-significant zero digits.
module test_value_display
    import mips_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] test_value,
    input  logic               freeze,
    output logic [AN_W-1:0]    an,
    output logic [SEG_W-1:0]   seg,
    output logic               dp,
    output logic               frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]   div_cnt;
    logic               wrap_c;
    logic               frame_end_c;
    digit_t             digit;
    digit_t             digit_next;
    logic [VALUE_W-1:0] shadow;
    logic [NIBBLE_W-1:0] nibble_c;
    logic [SEG_W-1:0]   dec_c;
    logic [AN_W-1:0]    lead_blank_c;
    logic [AN_W-1:0]    an_next;
    logic [SEG_W-1:0]   seg_next;

    assign wrap_c      = (div_cnt == CNT_MAX);
    assign frame_end_c = wrap_c && (digit == DIG3);
    assign dp          = 1'b1;

    // Per-digit dwell counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (wrap_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Shadow copy of test_value, loaded only at the end of a frame unless frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (frame_end_c && !freeze) begin
            shadow <= test_value;
        end
    end

    // Digit state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= DIG0;
        end else begin
            digit <= digit_next;
        end
    end

    // Advance to the next digit whenever the dwell counter wraps.
    always_comb begin
        digit_next = digit;
        if (wrap_c) begin
            case (digit)
                DIG0:    digit_next = DIG1;
                DIG1:    digit_next = DIG2;
                DIG2:    digit_next = DIG3;
                DIG3:    digit_next = DIG0;
                default: digit_next = DIG0;
            endcase
        end
    end

    // Leading-zero mask derived from the shadow value; digit 0 is never blanked.
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lead_blank_c    = '0;
        lead_blank_c[3] = (shadow[15:12] == 4'h0);
        lead_blank_c[2] = lead_blank_c[3] && (shadow[11:8] == 4'h0);
        lead_blank_c[1] = lead_blank_c[2] && (shadow[7:4] == 4'h0);
    end
`else
    assign lead_blank_c = '0;
`endif

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble_c),
        .seg_c  (dec_c)
    );

    // Select the nibble, anode and segment pattern for the current digit.
    always_comb begin
        an_next  = AN_OFF;
        nibble_c = shadow[3:0];
        seg_next = dec_c;
        case (digit)
            DIG0: begin
                an_next  = 4'b1110;
                nibble_c = shadow[3:0];
                if (lead_blank_c[0]) seg_next = SEG_BLANK;
            end
            DIG1: begin
                an_next  = 4'b1101;
                nibble_c = shadow[7:4];
                if (lead_blank_c[1]) seg_next = SEG_BLANK;
            end
            DIG2: begin
                an_next  = 4'b1011;
                nibble_c = shadow[11:8];
                if (lead_blank_c[2]) seg_next = SEG_BLANK;
            end
            DIG3: begin
                an_next  = 4'b0111;
                nibble_c = shadow[15:12];
                if (lead_blank_c[3]) seg_next = SEG_BLANK;
            end
            default: begin
                an_next  = AN_OFF;
                seg_next = SEG_BLANK;
            end
        endcase
    end

    // Glitch-free registered panel drive and frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            frame_tick <= frame_end_c;
        end
    end

endmodule

// File: tb/tb_test_value_display.sv
// Scoreboard bench for test_value_display with REFRESH_DIV=4.
module tb_test_value_display;

    localparam int unsigned R     = 4;
    localparam int unsigned FRAME = 4 * R;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       ft;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] test_value;
    logic        freeze;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int sb_checks = 0;

    exp_t        sb_q[$];
    int          k_edge;
    logic [15:0] m_shadow;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    test_value_display #(.REFRESH_DIV(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .test_value (test_value),
        .freeze     (freeze),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected panel state after edge k, given the shadow value held before that edge.
    function automatic exp_t predict(input int k, input logic [15:0] sh);
        exp_t e;
        int d;
        logic [15:0] upper;
        d     = ((k - 1) / R) % 4;
        upper = sh >> (4 * d);
        e.an  = ~(4'(1) << d);
        e.seg = seg_tab[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && upper == 16'h0) e.seg = 7'b1111111;
`endif
        e.ft  = ((k % FRAME) == 0);
        return e;
    endfunction

    // Reference model: counts edges since reset release and tracks the shadow value.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k_edge   = 0;
            m_shadow = 16'h0;
            sb_q.delete();
        end else begin
            k_edge++;
            sb_q.push_back(predict(k_edge, m_shadow));
            if ((k_edge % FRAME) == 0 && !freeze) m_shadow = test_value;
        end
    end

    // Monitor: compare DUT outputs on the falling edge.
    always @(negedge clk) begin
        if (!rst && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            sb_checks++;
            check("an", 16'(an), 16'(e.an));
            check("seg", 16'(seg), 16'(e.seg));
            check("frame_tick", 16'(frame_tick), 16'(e.ft));
            check("dp", 16'(dp), 16'h1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        test_value = 16'h1234;
        freeze     = 1'b0;
        #12;
        check("reset_an", 16'(an), 16'hF);
        check("reset_seg", 16'(seg), 16'h7F);
        check("reset_dp", 16'(dp), 16'h1);
        check("reset_ft", 16'(frame_tick), 16'h0);
        tick(2);
        rst = 1'b0;

        // First frame shows 0000, then 1234 after the boundary.
        tick(FRAME * 2 + 3);

        // Freeze across three frames while the input changes.
        freeze = 1'b1;
        test_value = 16'hABCD;
        tick(FRAME * 3);
        freeze = 1'b0;
        tick(FRAME * 2);

        // Mid-DIG1 change: must not tear the current frame.
        tick(FRAME - ((k_edge % FRAME)));
        tick(R + 2);
        test_value = 16'h5A0F;
        tick(FRAME * 2);

        // Leading-zero patterns.
        test_value = 16'h0042;
        tick(FRAME * 2);
        test_value = 16'h0000;
        tick(FRAME * 2);
        test_value = 16'h0300;
        tick(FRAME * 2);

        // Random changes and freeze toggles.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                logic [31:0] mask;
                mask = 32'h0000FFFF >> (4 * $urandom_range(0, 4));
                test_value = 16'($urandom() & mask);
            end
            if ($urandom_range(0, 19) == 0) freeze = ~freeze;
            tick(1);
        end
        freeze = 1'b0;

        // Reset asserted during DIG2.
        tick(FRAME - (k_edge % FRAME));
        tick(2 * R + 1);
        rst = 1'b1;
        #1;
        check("midreset_an", 16'(an), 16'hF);
        check("midreset_seg", 16'(seg), 16'h7F);
        check("midreset_ft", 16'(frame_tick), 16'h0);
        test_value = 16'hFEDC;
        tick(3);
        rst = 1'b0;
        tick(FRAME * 2 + 2);

        check("scoreboard_ran", 16'(sb_checks > 1000), 16'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
